// File: rtl/nco_sweep_pkg.sv
// Shared definitions for the NCO frequency sweep controller:
// the sweep state encoding and the default word widths.
package nco_sweep_pkg;

  localparam int FREQ_WIDTH_DEF  = 32;
  localparam int DWELL_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    DONE  = 2'd2
  } sweepState_t;

endpackage

// File: rtl/nco_sweep_if.sv
// Sweep request / NCO drive bundle between a sweep controller (slave)
// and the block that requests sweeps and observes status (master).
interface nco_sweep_if
  import nco_sweep_pkg::*;
#(
  parameter int FREQ_WIDTH  = FREQ_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) ();

  logic                   ipStart;
  logic                   ipAbort;
  logic [FREQ_WIDTH-1:0]  ipStartFreq;
  logic [FREQ_WIDTH-1:0]  ipStopFreq;
  logic [FREQ_WIDTH-1:0]  ipStep;
  logic                   ipDown;
  logic [DWELL_WIDTH-1:0] ipDwell;
  logic [FREQ_WIDTH-1:0]  opFrequency;
  logic                   opNcoReset;
  logic                   opBusy;
  logic                   opStep;
  logic                   opDone;

  modport master (
    output ipStart, ipAbort, ipStartFreq, ipStopFreq, ipStep, ipDown, ipDwell,
    input  opFrequency, opNcoReset, opBusy, opStep, opDone
  );

  modport slave (
    input  ipStart, ipAbort, ipStartFreq, ipStopFreq, ipStep, ipDown, ipDwell,
    output opFrequency, opNcoReset, opBusy, opStep, opDone
  );

endinterface

// File: rtl/nco_sweep.sv
// Stepped tuning-word sweep for an NCO: holds each word for the dwell time,
// clamps the final word to the stop frequency, then strobes done.
module nco_sweep
  import nco_sweep_pkg::*;
#(
  parameter int FREQ_WIDTH  = FREQ_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
  input  logic        ipClk,
  input  logic        Reset,
  nco_sweep_if.slave  sweepBus
);

  sweepState_t            stateR,     stateN;
  logic [FREQ_WIDTH-1:0]  freqR,      freqN;
  logic [FREQ_WIDTH-1:0]  stopR,      stopN;
  logic [FREQ_WIDTH-1:0]  stepR,      stepN;
  logic                   downR,      downN;
  logic [DWELL_WIDTH-1:0] dwellLoadR, dwellLoadN;
  logic [DWELL_WIDTH-1:0] counterR,   counterN;
  logic                   lastR,      lastN;
  logic                   ncoResetR,  ncoResetN;
  logic                   busyR,      busyN;
  logic                   stepStbR,   stepStbN;
  logic                   doneR,      doneN;

  logic [FREQ_WIDTH:0]    sumUp;
  logic [FREQ_WIDTH:0]    diffDown;
  logic                   clampUp;
  logic                   clampDown;
  logic                   clampHit;

  // The extra top bit is the carry (up) or borrow (down); either forces the
  // clamp, as does a zero step so a degenerate sweep can never stall.
  assign sumUp     = {1'b0, freqR} + {1'b0, stepR};
  assign diffDown  = {1'b0, freqR} - {1'b0, stepR};
  assign clampUp   = sumUp[FREQ_WIDTH]    || (sumUp[FREQ_WIDTH-1:0]    >= stopR);
  assign clampDown = diffDown[FREQ_WIDTH] || (diffDown[FREQ_WIDTH-1:0] <= stopR);
  assign clampHit  = (stepR == '0) || (downR ? clampDown : clampUp);

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    stateN     = stateR;
    freqN      = freqR;
    stopN      = stopR;
    stepN      = stepR;
    downN      = downR;
    dwellLoadN = dwellLoadR;
    counterN   = counterR;
    lastN      = lastR;
    ncoResetN  = 1'b0;
    busyN      = busyR;
    stepStbN   = 1'b0;
    doneN      = 1'b0;

    case (stateR)
      IDLE: begin
        if (sweepBus.ipStart) begin
          stateN     = DWELL;
          freqN      = sweepBus.ipStartFreq;
          stopN      = sweepBus.ipStopFreq;
          stepN      = sweepBus.ipStep;
          downN      = sweepBus.ipDown;
          dwellLoadN = (sweepBus.ipDwell == '0) ? DWELL_WIDTH'(1) : sweepBus.ipDwell;
          counterN   = (sweepBus.ipDwell == '0) ? DWELL_WIDTH'(1) : sweepBus.ipDwell;
          lastN      = 1'b0;
          ncoResetN  = 1'b1;
          busyN      = 1'b1;
        end else begin
          stateN     = IDLE;
        end
      end
      DWELL: begin
        if (sweepBus.ipAbort) begin
          stateN   = IDLE;
          busyN    = 1'b0;
          lastN    = 1'b0;
          counterN = '0;
        end else if (counterR <= DWELL_WIDTH'(1)) begin
          if (lastR) begin
            // The clamped stop word has served its dwell: finish the sweep.
            stateN   = DONE;
            busyN    = 1'b0;
            doneN    = 1'b1;
            lastN    = 1'b0;
            counterN = '0;
          end else begin
            freqN    = clampHit ? stopR :
                       (downR ? diffDown[FREQ_WIDTH-1:0] : sumUp[FREQ_WIDTH-1:0]);
            lastN    = clampHit;
            stepStbN = 1'b1;
            counterN = dwellLoadR;
          end
        end else begin
          counterN = counterR - DWELL_WIDTH'(1);
        end
      end
      DONE: begin
        stateN = IDLE;
      end
      default: begin
        stateN   = IDLE;
        busyN    = 1'b0;
        lastN    = 1'b0;
        counterN = '0;
      end
    endcase
  end

  // State and output registers; the NCO phase reset is held throughout reset.
  always_ff @(posedge ipClk) begin
    if (Reset) begin
      stateR     <= IDLE;
      freqR      <= '0;
      stopR      <= '0;
      stepR      <= '0;
      downR      <= 1'b0;
      dwellLoadR <= '0;
      counterR   <= '0;
      lastR      <= 1'b0;
      ncoResetR  <= 1'b1;
      busyR      <= 1'b0;
      stepStbR   <= 1'b0;
      doneR      <= 1'b0;
    end else begin
      stateR     <= stateN;
      freqR      <= freqN;
      stopR      <= stopN;
      stepR      <= stepN;
      downR      <= downN;
      dwellLoadR <= dwellLoadN;
      counterR   <= counterN;
      lastR      <= lastN;
      ncoResetR  <= ncoResetN;
      busyR      <= busyN;
      stepStbR   <= stepStbN;
      doneR      <= doneN;
    end
  end

  assign sweepBus.opFrequency = freqR;
  assign sweepBus.opNcoReset  = ncoResetR;
  assign sweepBus.opBusy      = busyR;
  assign sweepBus.opStep      = stepStbR;
  assign sweepBus.opDone      = doneR;

endmodule
